alu_ctrl_sequencer: RTL and testbench
=====================================

// Module: alu_ctrl_sequencer
// PURPOSE
//  Control-step FSM (T0-T5) sequencing one register-register ALU instruction over the single shared bus.
//  Drives bus-source select, load-enable select, PC increment, memory read and ALU op.
//  Waits on a memory-ready handshake and decodes a parametrised IR.
//  Sits beside Datapath; replaces hand-sequenced bench control with synthesizable logic.
// PARAMETERS
//  DATA_W    32  datapath/IR width
//  REG_CNT   16  GPR count; RIDX_W = $clog2(REG_CNT)
//  OPC_W     5   opcode field width
//  SEL_W     5   width of bus_sel / en_sel codes
//  ALU_W     4   alu_op width
//  MEM_TMO   15  T1 wait limit in cycles (used only with MEM_WAIT_TIMEOUT_EN)
// PORTS
//  clk        in   1       clock, rising edge
//  clr        in   1       synchronous active-high reset
//  start      in   1       begin instruction; sampled only in IDLE
//  ir_q       in   DATA_W  IR register contents
//  mem_ready  in   1       memory data valid on MDataIn
//  bus_sel    out  SEL_W   bus source code (GPR index; 19 Zlow, 20 PC, 21 MDR)
//  bus_vld    out  1       bus_sel meaningful
//  en_sel     out  SEL_W   load-enable code (GPR index; 21 MDR, 23 IR, 24 Z, 25 MAR, 27 Y)
//  en_vld     out  1       en_sel meaningful
//  inc_pc     out  1       PC <= PC+1 this cycle
//  mem_read   out  1       MDR input mux selects MDataIn
//  alu_op     out  ALU_W   ALU function, valid in T4 only, else 0
//  busy       out  1       state != IDLE
//  done       out  1       one-cycle pulse: instruction retired
//  fault      out  1       one-cycle pulse: illegal opcode or memory timeout
// BEHAVIOUR
//  IR fields: opc=ir_q[DATA_W-1 -: OPC_W]; ra, rb, rc = next three RIDX_W fields downward.
//  Elaboration error if DATA_W < OPC_W+3*RIDX_W.
//  States: IDLE,T0,T1,T2,T3,T4,T5,DONE,FAULT. Outputs: Moore, decoded from state reg (alu_op from ir_q in T4).
//  IDLE: all outputs 0. start=1 -> T0; start ignored in every other state.
//  T0: bus=PC, en=MAR, inc_pc=1 -> T1.
//  T1: mem_read=1, en=MDR every cycle; mem_ready=1 -> T2, else stay.
//  T2: bus=MDR, en=IR -> T3 (IR valid from T3 on).
//  T3: decode opc; illegal -> FAULT with no enables asserted; else bus=rb, en=Y -> T4.
//  T4: bus=rc, en=Z, alu_op=map(opc) -> T5.
//  T5: bus=Zlow, en=ra -> DONE.
//  DONE: done=1, other outputs 0 -> IDLE. FAULT: fault=1 -> IDLE.
//  Latency: start seen at edge k, mem_ready high in T1 -> done high in cycle k+7.
//  clr in any state: next state IDLE, all outputs 0 the following cycle; wait counter cleared.
//  bus_vld/en_vld 0 whenever the code is unused; never two enables in one cycle.
// CONFIGURATION
//  MEM_WAIT_TIMEOUT_EN defined: 4-bit-min counter runs in T1; MEM_TMO cycles without mem_ready -> FAULT.
//  Not defined: T1 waits indefinitely; fault only from illegal opcode.
// STRUCTURE
//  Package alu_seq_pkg: state enum, bus/enable code localparams (19,20,21,23,24,25,27),
//   opcode localparams, ALU op enum, function opc_to_alu() returning {legal, alu_op}.
//  Opcode map: 3 ADD=1, 4 SUB=2, 5 AND=3, 6 OR=4, 7 SHR=5, 8 SHRA=6, 9 SHL=7, 10 ROR=8, 11 ROL=9; others illegal.
//  Sub-module seq_ir_decode: combinational field split + legality.
// TESTING
//  ROL: ir_q=32'h589A8000 (opc 11, ra 1, rb 3, rc 5), mem_ready=1 -> T4 alu_op=9, T5 bus_sel=19 en_sel=1, done at k+7.
//  Mem wait: mem_ready low 4 cycles in T1 -> T1 held 5 cycles, mem_read=1 throughout, done at k+11.
//  Illegal: opc=31 -> fault pulse cycle after T3, no Y/Z/GPR enable ever, busy=0 next cycle.
//  Reset mid-op: clr in T4 -> next cycle busy=0, alu_op=0, en_vld=0; later start runs cleanly.
//  start held high through op and in DONE -> exactly one instruction per IDLE entry, back-to-back restart after DONE.
//  With MEM_WAIT_TIMEOUT_EN, MEM_TMO=15, mem_ready=0 -> fault after 15 T1 cycles; without, busy stays 1.

Source files
------------

// File: rtl/alu_ctrl_sequencer_pkg.sv
// Shared definitions for the ALU control-step sequencer: state codes, bus/enable codes, opcode map.
package alu_seq_pkg;

   typedef logic [3:0] state_t;

   localparam state_t S_IDLE  = 4'd0;
   localparam state_t S_T0    = 4'd1;
   localparam state_t S_T1    = 4'd2;
   localparam state_t S_T2    = 4'd3;
   localparam state_t S_T3    = 4'd4;
   localparam state_t S_T4    = 4'd5;
   localparam state_t S_T5    = 4'd6;
   localparam state_t S_DONE  = 4'd7;
   localparam state_t S_FAULT = 4'd8;

   // Non-GPR codes shared by bus_sel and en_sel
   localparam int unsigned CODE_ZLOW = 19;
   localparam int unsigned CODE_PC   = 20;
   localparam int unsigned CODE_MDR  = 21;
   localparam int unsigned CODE_IR   = 23;
   localparam int unsigned CODE_Z    = 24;
   localparam int unsigned CODE_MAR  = 25;
   localparam int unsigned CODE_Y    = 27;

   localparam int unsigned OPC_ADD  = 3;
   localparam int unsigned OPC_SUB  = 4;
   localparam int unsigned OPC_AND  = 5;
   localparam int unsigned OPC_OR   = 6;
   localparam int unsigned OPC_SHR  = 7;
   localparam int unsigned OPC_SHRA = 8;
   localparam int unsigned OPC_SHL  = 9;
   localparam int unsigned OPC_ROR  = 10;
   localparam int unsigned OPC_ROL  = 11;

   typedef enum logic [3:0] {
      ALU_NOP  = 4'd0,
      ALU_ADD  = 4'd1,
      ALU_SUB  = 4'd2,
      ALU_AND  = 4'd3,
      ALU_OR   = 4'd4,
      ALU_SHR  = 4'd5,
      ALU_SHRA = 4'd6,
      ALU_SHL  = 4'd7,
      ALU_ROR  = 4'd8,
      ALU_ROL  = 4'd9
   } alu_op_e;

   // Returns {legal, alu_op}; illegal opcodes yield {0, ALU_NOP}.
   function automatic logic [4:0] opc_to_alu(input logic [31:0] opc);
      logic [4:0] r;
      r = {1'b0, ALU_NOP};
      case (opc)
         OPC_ADD:  r = {1'b1, ALU_ADD};
         OPC_SUB:  r = {1'b1, ALU_SUB};
         OPC_AND:  r = {1'b1, ALU_AND};
         OPC_OR:   r = {1'b1, ALU_OR};
         OPC_SHR:  r = {1'b1, ALU_SHR};
         OPC_SHRA: r = {1'b1, ALU_SHRA};
         OPC_SHL:  r = {1'b1, ALU_SHL};
         OPC_ROR:  r = {1'b1, ALU_ROR};
         OPC_ROL:  r = {1'b1, ALU_ROL};
         default:  r = {1'b0, ALU_NOP};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_ctrl_sequencer_ir_decode.sv
// Combinational IR field split (opc, ra, rb, rc) plus opcode legality and ALU function lookup.
module seq_ir_decode
   import alu_seq_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int REG_CNT = 16,
   parameter int OPC_W   = 5,
   parameter int ALU_W   = 4,
   localparam int RIDX_W = $clog2(REG_CNT)
) (
   input  logic [DATA_W-1:0] i_ir,
   output logic [RIDX_W-1:0] o_ra,
   output logic [RIDX_W-1:0] o_rb,
   output logic [RIDX_W-1:0] o_rc,
   output logic              o_legal,
   output logic [ALU_W-1:0]  o_alu_op
);

   localparam int FIELD_W = OPC_W + 3*RIDX_W;

   logic [OPC_W-1:0] w_opc;
   logic [4:0]       w_map;

   if (DATA_W < FIELD_W) begin : g_width_check
      $error("seq_ir_decode: DATA_W too small for opcode and three register fields");
   end

   // Bits below the register fields carry no meaning for register-register ops
   if (DATA_W > FIELD_W) begin : g_low_bits
      logic w_unused_ir_low;
      assign w_unused_ir_low = ^i_ir[DATA_W-FIELD_W-1:0];
   end

   assign w_opc    = i_ir[DATA_W-1 -: OPC_W];
   assign o_ra     = i_ir[DATA_W-OPC_W-1 -: RIDX_W];
   assign o_rb     = i_ir[DATA_W-OPC_W-RIDX_W-1 -: RIDX_W];
   assign o_rc     = i_ir[DATA_W-OPC_W-2*RIDX_W-1 -: RIDX_W];
   assign w_map    = opc_to_alu(32'(w_opc));
   assign o_legal  = w_map[4];
   assign o_alu_op = ALU_W'(w_map[3:0]);

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// T0-T5 control-step sequencer for one register-register ALU instruction on the shared bus.
// Optional MEM_WAIT_TIMEOUT_EN: abandon the T1 memory wait after MEM_TMO cycles with a fault.
module alu_ctrl_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int REG_CNT = 16,
   parameter int OPC_W   = 5,
   parameter int SEL_W   = 5,
   parameter int ALU_W   = 4,
   parameter int MEM_TMO = 15
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic [DATA_W-1:0] ir_q,
   input  logic              mem_ready,
   output logic [SEL_W-1:0]  bus_sel,
   output logic              bus_vld,
   output logic [SEL_W-1:0]  en_sel,
   output logic              en_vld,
   output logic              inc_pc,
   output logic              mem_read,
   output logic [ALU_W-1:0]  alu_op,
   output logic              busy,
   output logic              done,
   output logic              fault
);

   localparam int RIDX_W = $clog2(REG_CNT);

   state_t            r_state;
   state_t            w_next;
   logic [RIDX_W-1:0] w_ra;
   logic [RIDX_W-1:0] w_rb;
   logic [RIDX_W-1:0] w_rc;
   logic              w_legal;
   logic [ALU_W-1:0]  w_alu_op;
   logic              w_tmo;

   seq_ir_decode #(
      .DATA_W  (DATA_W),
      .REG_CNT (REG_CNT),
      .OPC_W   (OPC_W),
      .ALU_W   (ALU_W)
   ) u_decode (
      .i_ir     (ir_q),
      .o_ra     (w_ra),
      .o_rb     (w_rb),
      .o_rc     (w_rc),
      .o_legal  (w_legal),
      .o_alu_op (w_alu_op)
   );

`ifdef MEM_WAIT_TIMEOUT_EN
   localparam int CNT_W = ($clog2(MEM_TMO + 1) > 4) ? $clog2(MEM_TMO + 1) : 4;

   logic [CNT_W-1:0] r_wait_cnt;

   // Counts T1 cycles already spent without mem_ready
   always_ff @(posedge clk) begin
      if (clr || r_state != S_T1 || mem_ready)
         r_wait_cnt <= '0;
      else
         r_wait_cnt <= r_wait_cnt + 1'b1;
   end

   assign w_tmo = (r_wait_cnt == CNT_W'(MEM_TMO - 1));
`else
   localparam int unused_tmo_cfg = MEM_TMO;

   assign w_tmo = 1'b0;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_T0;
         S_T0:    w_next = S_T1;
         S_T1: begin
            if (mem_ready)  w_next = S_T2;
            else if (w_tmo) w_next = S_FAULT;
         end
         S_T2:    w_next = S_T3;
         S_T3:    w_next = w_legal ? S_T4 : S_FAULT;
         S_T4:    w_next = S_T5;
         S_T5:    w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         S_FAULT: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      bus_sel  = '0;
      bus_vld  = 1'b0;
      en_sel   = '0;
      en_vld   = 1'b0;
      inc_pc   = 1'b0;
      mem_read = 1'b0;
      alu_op   = '0;
      done     = 1'b0;
      fault    = 1'b0;
      busy     = (r_state != S_IDLE);
      case (r_state)
         S_T0: begin
            bus_sel = SEL_W'(CODE_PC);  bus_vld = 1'b1;
            en_sel  = SEL_W'(CODE_MAR); en_vld  = 1'b1;
            inc_pc  = 1'b1;
         end
         S_T1: begin
            mem_read = 1'b1;
            en_sel   = SEL_W'(CODE_MDR); en_vld = 1'b1;
         end
         S_T2: begin
            bus_sel = SEL_W'(CODE_MDR); bus_vld = 1'b1;
            en_sel  = SEL_W'(CODE_IR);  en_vld  = 1'b1;
         end
         // Illegal opcode: nothing on the bus and nothing loaded on the way to FAULT
         S_T3: begin
            if (w_legal) begin
               bus_sel = SEL_W'(w_rb);   bus_vld = 1'b1;
               en_sel  = SEL_W'(CODE_Y); en_vld  = 1'b1;
            end
         end
         S_T4: begin
            bus_sel = SEL_W'(w_rc);   bus_vld = 1'b1;
            en_sel  = SEL_W'(CODE_Z); en_vld  = 1'b1;
            alu_op  = w_alu_op;
         end
         S_T5: begin
            bus_sel = SEL_W'(CODE_ZLOW); bus_vld = 1'b1;
            en_sel  = SEL_W'(w_ra);      en_vld  = 1'b1;
         end
         S_DONE:  done  = 1'b1;
         S_FAULT: fault = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Scoreboard bench: driver queues the per-cycle output trace expected for each instruction, monitor compares every cycle.
module tb_alu_ctrl_sequencer;

   localparam int DATA_W  = 32;
   localparam int MEM_TMO = 15;

   localparam int C_ZLOW = 19, C_PC = 20, C_MDR = 21, C_IR = 23, C_Z = 24, C_MAR = 25, C_Y = 27;

   logic              clk = 1'b0;
   logic              clr;
   logic              start;
   logic [DATA_W-1:0] ir_q;
   logic              mem_ready;
   logic [4:0]        bus_sel;
   logic              bus_vld;
   logic [4:0]        en_sel;
   logic              en_vld;
   logic              inc_pc;
   logic              mem_read;
   logic [3:0]        alu_op;
   logic              busy;
   logic              done;
   logic              fault;

   always #5 clk = ~clk;

   alu_ctrl_sequencer #(
      .DATA_W  (DATA_W),
      .REG_CNT (16),
      .OPC_W   (5),
      .SEL_W   (5),
      .ALU_W   (4),
      .MEM_TMO (MEM_TMO)
   ) dut (
      .clk       (clk),
      .clr       (clr),
      .start     (start),
      .ir_q      (ir_q),
      .mem_ready (mem_ready),
      .bus_sel   (bus_sel),
      .bus_vld   (bus_vld),
      .en_sel    (en_sel),
      .en_vld    (en_vld),
      .inc_pc    (inc_pc),
      .mem_read  (mem_read),
      .alu_op    (alu_op),
      .busy      (busy),
      .done      (done),
      .fault     (fault)
   );

   typedef struct packed {
      logic       bus_vld;
      logic [4:0] bus_sel;
      logic       en_vld;
      logic [4:0] en_sel;
      logic       inc_pc;
      logic       mem_read;
      logic [3:0] alu_op;
      logic       busy;
      logic       done;
      logic       fault;
   } obs_t;

   obs_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // One busy cycle: bus/en code of -1 means that code is unused
   function automatic obs_t step(input int bus, input int en, input bit inc, input bit rd, input int op);
      obs_t o;
      o = '0;
      if (bus >= 0) begin o.bus_vld = 1'b1; o.bus_sel = 5'(bus); end
      if (en >= 0)  begin o.en_vld  = 1'b1; o.en_sel  = 5'(en);  end
      o.inc_pc   = inc;
      o.mem_read = rd;
      o.alu_op   = 4'(op);
      o.busy     = 1'b1;
      return o;
   endfunction

   // Reference trace of one instruction; entries after index 'cut' are dropped (cut<0 keeps all)
   task automatic push_expect(input logic [31:0] ir, input int w, input int cut, output int n);
      obs_t t[$];
      obs_t fin;
      int   opc, ra, rb, rc, t1_cycles;
      bit   tmo;
      opc = int'(ir[31:27]);
      ra  = int'(ir[26:23]);
      rb  = int'(ir[22:19]);
      rc  = int'(ir[18:15]);
      t1_cycles = w + 1;
      tmo = 1'b0;
`ifdef MEM_WAIT_TIMEOUT_EN
      if (w >= MEM_TMO) begin t1_cycles = MEM_TMO; tmo = 1'b1; end
`endif
      t.push_back(step(C_PC, C_MAR, 1, 0, 0));
      repeat (t1_cycles) t.push_back(step(-1, C_MDR, 0, 1, 0));
      fin = '0;
      fin.busy = 1'b1;
      if (tmo) begin
         fin.fault = 1'b1;
         t.push_back(fin);
      end else begin
         t.push_back(step(C_MDR, C_IR, 0, 0, 0));
         if (opc >= 3 && opc <= 11) begin
            t.push_back(step(rb, C_Y, 0, 0, 0));
            t.push_back(step(rc, C_Z, 0, 0, opc - 2));
            t.push_back(step(C_ZLOW, ra, 0, 0, 0));
            fin.done = 1'b1;
         end else begin
            t.push_back(step(-1, -1, 0, 0, 0));
            fin.fault = 1'b1;
         end
         t.push_back(fin);
      end
      n = 0;
      foreach (t[i]) begin
         if (cut < 0 || i <= cut) begin
            exp_q.push_back(t[i]);
            n++;
         end
      end
   endtask

   // Issues one instruction; mem_ready is low for w T1 cycles, then high. clr is pulsed in cycle 'abort'.
   task automatic run_instr(input logic [31:0] ir, input int w, input bit hold, input int abort);
      int n;
      #1;
      ir_q      = ir;
      start     = 1'b1;
      mem_ready = 1'($urandom);
      @(posedge clk);
      push_expect(ir, w, abort, n);
      for (int c = 0; c < n; c++) begin
         #1;
         start = hold ? 1'b1 : 1'($urandom);
         if (c >= 1 && c <= w)  mem_ready = 1'b0;
         else if (c == w + 1)   mem_ready = 1'b1;
         else                   mem_ready = 1'($urandom);
         if (c == abort) clr = 1'b1;
         @(posedge clk);
      end
      if (abort >= 0) begin
         #1;
         clr   = 1'b0;
         start = 1'b0;
      end
   endtask

   task automatic idle(input int cycles);
      #1;
      start = 1'b0;
      repeat (cycles) @(posedge clk);
   endtask

   // Monitor: every cycle the DUT must show the next queued entry, or all-zero outputs when idle
   initial begin
      obs_t act, req;
      forever begin
         @(negedge clk);
         act = {bus_vld, bus_sel, en_vld, en_sel, inc_pc, mem_read, alu_op, busy, done, fault};
         req = (exp_q.size() > 0) ? exp_q.pop_front() : obs_t'('0);
         n_checks++;
         if (act !== req) begin
            n_fail++;
            $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, act, req);
         end
      end
   end

   initial begin
      logic [31:0] ir;
      int          w, ab, tmo_abort;
      bit          hold;

      clr = 1'b1; start = 1'b0; ir_q = '0; mem_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 clr = 1'b0;
      idle(2);

      // ROL r1 <- r3, r5 with immediate memory ready
      run_instr(32'h589A8000, 0, 0, -1);
      idle(2);
      // memory slow for 4 cycles
      run_instr(32'h589A8000, 4, 0, -1);
      idle(1);
      // illegal opcodes around the legal range
      ir = $urandom; ir[31:27] = 5'd31; run_instr(ir, 1, 0, -1);
      ir = $urandom; ir[31:27] = 5'd0;  run_instr(ir, 0, 0, -1);
      ir = $urandom; ir[31:27] = 5'd2;  run_instr(ir, 2, 0, -1);
      ir = $urandom; ir[31:27] = 5'd12; run_instr(ir, 0, 0, -1);
      ir = $urandom; ir[31:27] = 5'd3;  run_instr(ir, 0, 0, -1);
      idle(2);
      // clr while in T4 (w=2 puts T4 at cycle index 6), then a clean instruction
      ir = $urandom; ir[31:27] = 5'd4; run_instr(ir, 2, 0, 6);
      idle(2);
      ir = $urandom; ir[31:27] = 5'd5; run_instr(ir, 1, 0, -1);
      // start held high: one instruction per IDLE entry, back to back
      for (int i = 0; i < 3; i++) begin
         ir = $urandom; ir[31:27] = 5'(3 + i * 3);
         run_instr(ir, i, 1, -1);
      end
      idle(2);
      // memory never ready
`ifdef MEM_WAIT_TIMEOUT_EN
      tmo_abort = -1;
`else
      tmo_abort = 40;
`endif
      ir = $urandom; ir[31:27] = 5'd6; run_instr(ir, 1000, 0, tmo_abort);
      idle(2);

      for (int i = 0; i < 60; i++) begin
         ir = $urandom;
         ir[31:27] = 5'($urandom_range(0, 13));
         w    = $urandom_range(0, 6);
         hold = 1'($urandom);
         ab   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 9) : -1;
         run_instr(ir, w, hold, ab);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end

      idle(4);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL trace_drained actual=%0d entries left required=0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
